// File: rtl/riscv_biu2wb_b3_if.sv
// Wishbone B3 bus seen from the bridge: master drives the cycle, slave answers.
interface riscv_biu2wb_b3_if #(
    parameter int XLEN = 64,
    parameter int PLEN = 64
);
    logic [PLEN-1:0]   wb_adr_o;
    logic [XLEN-1:0]   wb_dat_o;
    logic [XLEN/8-1:0] wb_sel_o;
    logic              wb_we_o;
    logic              wb_cyc_o;
    logic              wb_stb_o;
    logic [2:0]        wb_cti_o;
    logic [1:0]        wb_bte_o;
    logic [XLEN-1:0]   wb_dat_i;
    logic              wb_ack_i;
    logic              wb_err_i;
    logic              wb_rty_i;

    modport master (
        output wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        input  wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );

    modport slave (
        input  wb_adr_o, wb_dat_o, wb_sel_o, wb_we_o, wb_cyc_o, wb_stb_o, wb_cti_o, wb_bte_o,
        output wb_dat_i, wb_ack_i, wb_err_i, wb_rty_i
    );
endinterface

// File: rtl/riscv_biu2wb_b3.sv
// BIU to Wishbone B3 bridge: single and burst transfers with retry, error and timeout handling.
module riscv_biu2wb_b3 #(
    parameter int XLEN    = 64,
    parameter int PLEN    = 64,
    parameter int MAX_RTY = 4,
    parameter int TIMEOUT = 255
) (
    input  logic                 HCLK,
    input  logic                 HRESETn,
    riscv_biu2wb_b3_if.master    wb,
    input  logic                 biu_stb_i,
    output logic                 biu_stb_ack_o,
    output logic                 biu_d_ack_o,
    input  logic [PLEN-1:0]      biu_adri_i,
    output logic [PLEN-1:0]      biu_adro_o,
    input  logic [2:0]           biu_size_i,
    input  logic [2:0]           biu_type_i,
    input  logic                 biu_lock_i,
    input  logic                 biu_we_i,
    input  logic [XLEN-1:0]      biu_d_i,
    output logic [XLEN-1:0]      biu_q_o,
    output logic                 biu_ack_o,
    output logic                 biu_err_o
);
    localparam int BYTES = XLEN / 8;
    localparam int OFFW  = $clog2(BYTES);

    localparam logic [2:0] WRAP4  = 3'b010, INCR4  = 3'b011;
    localparam logic [2:0] WRAP8  = 3'b100, INCR8  = 3'b101;
    localparam logic [2:0] WRAP16 = 3'b110, INCR16 = 3'b111;

    typedef enum logic [1:0] {IDLE, BUS, RETRY} state_t;

    state_t            state_reg, state_next;
    logic [PLEN-1:0]   adr_reg, adr_next;
    logic [XLEN-1:0]   dat_reg, dat_next;
    logic              we_reg, we_next;
    logic [2:0]        size_reg, size_next;
    logic              burst_reg, burst_next;
    logic              wrap_reg, wrap_next;
    logic [7:0]        wmask_reg, wmask_next;
    logic [1:0]        bte_reg, bte_next;
    logic [4:0]        beats_reg, beats_next;
    logic [3:0]        rty_reg, rty_next;
    logic [7:0]        tmo_reg, tmo_next;
    logic              cyc_reg, cyc_next;
    logic              stb_reg, stb_next;
    logic              err_reg, err_next;

    logic [4:0]        acc_beats;
    logic              acc_burst, acc_wrap;
    logic [1:0]        acc_bte;
    logic [7:0]        acc_mask;
    logic              rsp_err, rsp_rty, rsp_ack, in_bus, beat_last, abort;
    logic [PLEN-1:0]   adr_inc, adr_wrap;
    logic [7:0]        size_mask;
    logic [BYTES-1:0]  sel_single;

    // Response priority: err beats rty beats ack.
    assign rsp_err   = wb.wb_err_i;
    assign rsp_rty   = wb.wb_rty_i & ~wb.wb_err_i;
    assign rsp_ack   = wb.wb_ack_i & ~wb.wb_err_i & ~wb.wb_rty_i;
    assign in_bus    = (state_reg == BUS);
    assign beat_last = (beats_reg == 5'd1);

    assign adr_inc  = adr_reg + PLEN'(BYTES);
    assign adr_wrap = {adr_reg[PLEN-1:8], (adr_reg[7:0] & ~wmask_reg) | (adr_inc[7:0] & wmask_reg)};

    always_comb begin
        acc_beats = 5'd1;
        acc_burst = 1'b0;
        acc_wrap  = 1'b0;
        acc_bte   = 2'b00;
        acc_mask  = 8'h00;
        case (biu_type_i)
            WRAP4:  begin acc_beats = 5'd4;  acc_burst = 1'b1; acc_wrap = 1'b1; acc_bte = 2'b01; acc_mask = 8'(4*BYTES-1);  end
            INCR4:  begin acc_beats = 5'd4;  acc_burst = 1'b1; end
            WRAP8:  begin acc_beats = 5'd8;  acc_burst = 1'b1; acc_wrap = 1'b1; acc_bte = 2'b10; acc_mask = 8'(8*BYTES-1);  end
            INCR8:  begin acc_beats = 5'd8;  acc_burst = 1'b1; end
            WRAP16: begin acc_beats = 5'd16; acc_burst = 1'b1; acc_wrap = 1'b1; acc_bte = 2'b11; acc_mask = 8'(16*BYTES-1); end
            INCR16: begin acc_beats = 5'd16; acc_burst = 1'b1; end
            default: ;
        endcase
    end

    always_comb begin
        case (size_reg)
            3'b000:  size_mask = 8'h01;
            3'b001:  size_mask = 8'h03;
            3'b010:  size_mask = 8'h0F;
            default: size_mask = 8'hFF;
        endcase
        sel_single = BYTES'(size_mask) << adr_reg[OFFW-1:0];
    end

    always_comb begin
        state_next = state_reg;
        adr_next   = adr_reg;
        dat_next   = dat_reg;
        we_next    = we_reg;
        size_next  = size_reg;
        burst_next = burst_reg;
        wrap_next  = wrap_reg;
        wmask_next = wmask_reg;
        bte_next   = bte_reg;
        beats_next = beats_reg;
        rty_next   = rty_reg;
        tmo_next   = tmo_reg;
        cyc_next   = cyc_reg;
        stb_next   = stb_reg;
        err_next   = 1'b0;
        abort      = 1'b0;
        case (state_reg)
            IDLE: begin
                if (biu_stb_i) begin
                    state_next = BUS;
                    adr_next   = biu_adri_i;
                    dat_next   = biu_d_i;
                    we_next    = biu_we_i;
                    size_next  = biu_size_i;
                    burst_next = acc_burst;
                    wrap_next  = acc_wrap;
                    wmask_next = acc_mask;
                    bte_next   = acc_bte;
                    beats_next = acc_beats;
                    rty_next   = 4'd0;
                    tmo_next   = 8'd0;
                    cyc_next   = 1'b1;
                    stb_next   = 1'b1;
                end else begin
                    cyc_next = cyc_reg & biu_lock_i;
                end
            end
            BUS: begin
                if (rsp_err) begin
                    abort = 1'b1;
                end else if (rsp_rty) begin
                    if (rty_reg == 4'(MAX_RTY-1)) begin
                        abort = 1'b1;
                    end else begin
                        state_next = RETRY;
                        rty_next   = rty_reg + 4'd1;
                        cyc_next   = 1'b0;
                        stb_next   = 1'b0;
                    end
                end else if (rsp_ack) begin
                    rty_next   = 4'd0;
                    tmo_next   = 8'd0;
                    beats_next = beats_reg - 5'd1;
                    if (beat_last) begin
                        state_next = IDLE;
                        stb_next   = 1'b0;
                        cyc_next   = biu_lock_i;
                    end else begin
                        adr_next = wrap_reg ? adr_wrap : adr_inc;
                        if (we_reg) dat_next = biu_d_i;
                    end
                end else if (TIMEOUT != 0) begin
                    if (tmo_reg == 8'(TIMEOUT-1)) abort = 1'b1;
                    else tmo_next = tmo_reg + 8'd1;
                end
            end
            RETRY: begin
                state_next = BUS;
                cyc_next   = 1'b1;
                stb_next   = 1'b1;
                tmo_next   = 8'd0;
            end
            default: state_next = IDLE;
        endcase
        // Any abort drops the whole cycle, flushes the remaining beats and flags the error.
        if (abort) begin
            state_next = IDLE;
            cyc_next   = 1'b0;
            stb_next   = 1'b0;
            err_next   = 1'b1;
            beats_next = 5'd0;
            rty_next   = 4'd0;
            tmo_next   = 8'd0;
        end
    end

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            state_reg <= IDLE;
            adr_reg   <= '0;
            dat_reg   <= '0;
            we_reg    <= 1'b0;
            size_reg  <= 3'b000;
            burst_reg <= 1'b0;
            wrap_reg  <= 1'b0;
            wmask_reg <= 8'h00;
            bte_reg   <= 2'b00;
            beats_reg <= 5'd0;
            rty_reg   <= 4'd0;
            tmo_reg   <= 8'd0;
            cyc_reg   <= 1'b0;
            stb_reg   <= 1'b0;
            err_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            adr_reg   <= adr_next;
            dat_reg   <= dat_next;
            we_reg    <= we_next;
            size_reg  <= size_next;
            burst_reg <= burst_next;
            wrap_reg  <= wrap_next;
            wmask_reg <= wmask_next;
            bte_reg   <= bte_next;
            beats_reg <= beats_next;
            rty_reg   <= rty_next;
            tmo_reg   <= tmo_next;
            cyc_reg   <= cyc_next;
            stb_reg   <= stb_next;
            err_reg   <= err_next;
        end
    end

    // Qualifiers are gated by stb so an idle or retrying bus shows all zeros.
    assign wb.wb_adr_o = adr_reg;
    assign wb.wb_dat_o = dat_reg;
    assign wb.wb_we_o  = we_reg & stb_reg;
    assign wb.wb_cyc_o = cyc_reg;
    assign wb.wb_stb_o = stb_reg;
    assign wb.wb_sel_o = !stb_reg ? '0 : (burst_reg ? '1 : sel_single);
    assign wb.wb_cti_o = (!stb_reg || !burst_reg) ? 3'b000 : (beat_last ? 3'b111 : 3'b010);
    assign wb.wb_bte_o = stb_reg ? bte_reg : 2'b00;

    assign biu_stb_ack_o = biu_stb_i & (state_reg == IDLE);
    assign biu_ack_o     = rsp_ack & in_bus;
    assign biu_d_ack_o   = rsp_ack & in_bus & we_reg & ~beat_last;
    assign biu_q_o       = wb.wb_dat_i;
    assign biu_adro_o    = adr_reg;
    assign biu_err_o     = err_reg;
endmodule

// File: tb/tb_riscv_biu2wb_b3.sv
// Scoreboard bench for riscv_biu2wb_b3: directed requests, scripted slave, decoupled monitor.
module tb_riscv_biu2wb_b3;
    localparam logic [2:0] SINGLE = 3'b000, WRAP4 = 3'b010, INCR4 = 3'b011;
    localparam logic [2:0] INCR8  = 3'b101, INCR16 = 3'b111;
    localparam logic [63:0] RBASE = 64'h0BAD_F00D_0000_0000;

    typedef struct {
        bit          is_err;
        logic [63:0] adr;
        logic [7:0]  sel;
        logic [2:0]  cti;
        logic [1:0]  bte;
        logic        we;
        logic [63:0] dat;
        int          stbs;
    } exp_t;

    logic        HCLK = 1'b0;
    logic        HRESETn = 1'b0;
    logic        biu_stb_i = 1'b0, biu_lock_i = 1'b0, biu_we_i = 1'b0;
    logic [63:0] biu_adri_i = '0, biu_d_i = '0;
    logic [2:0]  biu_size_i = '0, biu_type_i = '0;
    logic        biu_stb_ack_o, biu_d_ack_o, biu_ack_o, biu_err_o;
    logic [63:0] biu_adro_o, biu_q_o;

    riscv_biu2wb_b3_if #(.XLEN(64), .PLEN(64)) bus ();

    riscv_biu2wb_b3 #(.XLEN(64), .PLEN(64), .MAX_RTY(2), .TIMEOUT(5)) dut (
        .HCLK(HCLK), .HRESETn(HRESETn), .wb(bus.master),
        .biu_stb_i(biu_stb_i), .biu_stb_ack_o(biu_stb_ack_o), .biu_d_ack_o(biu_d_ack_o),
        .biu_adri_i(biu_adri_i), .biu_adro_o(biu_adro_o), .biu_size_i(biu_size_i),
        .biu_type_i(biu_type_i), .biu_lock_i(biu_lock_i), .biu_we_i(biu_we_i),
        .biu_d_i(biu_d_i), .biu_q_o(biu_q_o), .biu_ack_o(biu_ack_o), .biu_err_o(biu_err_o)
    );

    always #5 HCLK = ~HCLK;

    exp_t        exp_q[$];
    int          resp_q[$];
    logic [63:0] wdata[16];
    logic [63:0] w4_adr[4] = '{64'h18, 64'h00, 64'h08, 64'h10};
    int          widx = 0, rd_cnt = 0, acc_fail = 0, exp_dack = 0;
    bit          end_req = 1'b0;

    // Monitor-owned tallies
    int n_chk = 0, n_fail = 0, stb_cnt = 0, dack_cnt = 0;

    task automatic exp_ack(input logic [63:0] adr, input logic [7:0] sel, input logic [2:0] cti,
                           input logic [1:0] bte, input logic we, input logic [63:0] dat, input int stbs);
        exp_t e;
        e.is_err = 1'b0; e.adr = adr; e.sel = sel; e.cti = cti; e.bte = bte;
        e.we = we; e.dat = dat; e.stbs = stbs;
        exp_q.push_back(e);
    endtask

    task automatic exp_err(input int stbs);
        exp_t e;
        e.is_err = 1'b1; e.adr = '0; e.sel = '0; e.cti = '0; e.bte = '0;
        e.we = 1'b0; e.dat = '0; e.stbs = stbs;
        exp_q.push_back(e);
    endtask

    // One clock of stimulus: feed write data, release accepted request, answer the current beat.
    task automatic step();
        bit acc, cons;
        int code;
        @(negedge HCLK);
        acc  = biu_stb_ack_o;
        cons = biu_stb_ack_o | biu_d_ack_o;
        @(posedge HCLK);
        #1;
        if (acc) biu_stb_i = 1'b0;
        if (cons && widx < 15) widx++;
        biu_d_i = wdata[widx];
        bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
        if (bus.wb_cyc_o && bus.wb_stb_o) begin
            code = (resp_q.size() > 0) ? resp_q.pop_front() : 0;
            case (code)
                1: begin bus.wb_ack_i = 1'b1; bus.wb_dat_i = RBASE + 64'(rd_cnt); rd_cnt++; end
                2: bus.wb_rty_i = 1'b1;
                3: bus.wb_err_i = 1'b1;
                4: begin bus.wb_err_i = 1'b1; bus.wb_ack_i = 1'b1; end
                default: ;
            endcase
        end
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic issue(input logic [63:0] adr, input logic [2:0] size, input logic [2:0] typ,
                         input logic we, input logic lock);
        biu_adri_i = adr; biu_size_i = size; biu_type_i = typ; biu_we_i = we; biu_lock_i = lock;
        widx = 0; rd_cnt = 0; biu_d_i = wdata[0];
        biu_stb_i = 1'b1;
        for (int i = 0; i < 20 && biu_stb_i; i++) step();
        if (biu_stb_i) begin acc_fail++; biu_stb_i = 1'b0; end
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    task automatic check_event(input bit is_err);
        exp_t e;
        if (exp_q.size() == 0) begin
            n_chk++; n_fail++;
            $display("FAIL unexpected_event: got %s expected none", is_err ? "err" : "ack");
        end else begin
            e = exp_q.pop_front();
            chk("event_kind", 64'(is_err), 64'(e.is_err));
            chk("stb_cycles", 64'(stb_cnt), 64'(e.stbs));
            if (e.is_err) begin
                chk("err_cyc", 64'(bus.wb_cyc_o), 64'd0);
                chk("err_stb", 64'(bus.wb_stb_o), 64'd0);
            end else begin
                chk("adro", biu_adro_o, e.adr);
                chk("sel", 64'(bus.wb_sel_o), 64'(e.sel));
                chk("cti", 64'(bus.wb_cti_o), 64'(e.cti));
                chk("bte", 64'(bus.wb_bte_o), 64'(e.bte));
                chk("we", 64'(bus.wb_we_o), 64'(e.we));
                if (e.we) chk("wdata", bus.wb_dat_o, e.dat);
                else      chk("rdata", biu_q_o, e.dat);
            end
        end
        stb_cnt = 0;
    endtask

    initial begin
        forever begin
            @(negedge HCLK or negedge HRESETn);
            if (!HRESETn) begin
                #1;
                stb_cnt = 0;
                chk("rst_cyc", 64'(bus.wb_cyc_o), 64'd0);
                chk("rst_stb", 64'(bus.wb_stb_o), 64'd0);
                chk("rst_adr", bus.wb_adr_o, 64'd0);
                chk("rst_dat", bus.wb_dat_o, 64'd0);
                chk("rst_sel", 64'(bus.wb_sel_o), 64'd0);
                chk("rst_cti", 64'(bus.wb_cti_o), 64'd0);
                chk("rst_bte", 64'(bus.wb_bte_o), 64'd0);
                chk("rst_we", 64'(bus.wb_we_o), 64'd0);
                chk("rst_err", 64'(biu_err_o), 64'd0);
            end else begin
                if (bus.wb_cyc_o && bus.wb_stb_o) stb_cnt++;
                if (biu_d_ack_o) dack_cnt++;
                if (biu_ack_o) check_event(1'b0);
                if (biu_err_o) check_event(1'b1);
                if (end_req) begin
                    chk("queue_drained", 64'(exp_q.size()), 64'd0);
                    chk("d_ack_pulses", 64'(dack_cnt), 64'(exp_dack));
                    chk("accept_stalls", 64'(acc_fail), 64'd0);
                    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
                    $finish;
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach end of test");
        $fatal(1);
    end

    initial begin
        bus.wb_dat_i = '0; bus.wb_ack_i = 1'b0; bus.wb_err_i = 1'b0; bus.wb_rty_i = 1'b0;
        for (int k = 0; k < 16; k++) wdata[k] = 64'hDA7A_0000_1234_5600 + 64'(k) * 64'h1_0000_0001;
        run(3);
        HRESETn = 1'b1;
        run(2);

        // Read SINGLE half-word at 0x1006, ack on the second strobe cycle
        resp_q = '{0, 1};
        exp_ack(64'h1006, 8'hC0, 3'b000, 2'b00, 1'b0, RBASE, 2);
        issue(64'h1006, 3'b001, SINGLE, 1'b0, 1'b0);
        run(5);

        // Write WRAP4 at 0x18: 18,00,08,10
        resp_q = '{1, 1, 1, 1};
        for (int k = 0; k < 4; k++)
            exp_ack(w4_adr[k], 8'hFF, (k == 3) ? 3'b111 : 3'b010, 2'b01, 1'b1, wdata[k], 1);
        exp_dack += 3;
        issue(64'h18, 3'b011, WRAP4, 1'b1, 1'b0);
        run(6);

        // Read INCR8 at 0x100, retry on the third beat
        resp_q = '{1, 1, 2, 1, 1, 1, 1, 1, 1};
        for (int k = 0; k < 8; k++)
            exp_ack(64'h100 + 64'(8 * k), 8'hFF, (k == 7) ? 3'b111 : 3'b010, 2'b00, 1'b0,
                    RBASE + 64'(k), (k == 2) ? 2 : 1);
        issue(64'h100, 3'b011, INCR8, 1'b0, 1'b0);
        run(14);

        // Two retries on beat 1 exhaust MAX_RTY=2
        resp_q = '{1, 2, 2};
        exp_ack(64'h200, 8'hFF, 3'b010, 2'b00, 1'b0, RBASE, 1);
        exp_err(2);
        issue(64'h200, 3'b011, INCR4, 1'b0, 1'b0);
        run(6);

        // Silent slave: timeout after 5 strobe cycles
        resp_q.delete();
        exp_err(5);
        issue(64'h304, 3'b010, SINGLE, 1'b0, 1'b0);
        run(10);

        // err and ack together: err wins
        resp_q = '{4};
        exp_err(1);
        issue(64'h400, 3'b011, SINGLE, 1'b0, 1'b0);
        run(4);

        // Locked INCR16 cut by reset after three beats
        resp_q = '{1, 1, 1};
        for (int k = 0; k < 3; k++)
            exp_ack(64'h1000 + 64'(8 * k), 8'hFF, 3'b010, 2'b00, 1'b0, RBASE + 64'(k), 1);
        issue(64'h1000, 3'b011, INCR16, 1'b0, 1'b1);
        run(3);
        #2;
        HRESETn = 1'b0;
        resp_q.delete();
        run(2);
        biu_lock_i = 1'b0;
        HRESETn = 1'b1;
        run(2);

        // Clean restart: byte write at 0x2003
        resp_q = '{1};
        exp_ack(64'h2003, 8'h08, 3'b000, 2'b00, 1'b1, wdata[0], 1);
        issue(64'h2003, 3'b000, SINGLE, 1'b1, 1'b0);
        run(4);

        end_req = 1'b1;
        run(5);
    end
endmodule

// File: doc/riscv_biu2wb_b3.md
RISCV_BIU2WB_B3 -- requirements
Module: riscv_biu2wb_b3

Interface
REQ-001 XLEN, 64, data width; SHALL support 32 and 64.
REQ-002 PLEN, 64, physical address width.
REQ-003 MAX_RTY, 4, retries per beat before the beat is converted to an error; range 1-15.
REQ-004 TIMEOUT, 255, cycles without ack/err/rty before abort; 0 disables; range 0-255.
REQ-005 HCLK  in  1  single clock, rising edge.
REQ-006 HRESETn  in  1  reset, asynchronous, active-low.
REQ-007 wb_adr_o  out  PLEN  beat address.
REQ-008 wb_dat_o  out  XLEN  write data.
REQ-009 wb_sel_o  out  XLEN/8  byte selects.
REQ-010 wb_we_o  out  1  write enable.
REQ-011 wb_cyc_o  out  1  bus cycle.
REQ-012 wb_stb_o  out  1  strobe.
REQ-013 wb_cti_o  out  3  cycle type: 000 classic, 010 incrementing, 111 end-of-burst.
REQ-014 wb_bte_o  out  2  burst type: 00 linear, 01 wrap4, 10 wrap8, 11 wrap16.
REQ-015 wb_dat_i  in  XLEN  read data.
REQ-016 wb_ack_i  in  1  beat acknowledge.
REQ-017 wb_err_i  in  1  beat error.
REQ-018 wb_rty_i  in  1  beat retry.
REQ-019 biu_stb_i  in  1  request.
REQ-020 biu_stb_ack_o  out  1  request accepted.
REQ-021 biu_d_ack_o  out  1  write data consumed; present next biu_d_i.
REQ-022 biu_adri_i  in  PLEN  request start address.
REQ-023 biu_adro_o  out  PLEN  address of the beat being acknowledged.
REQ-024 biu_size_i  in  3  size: 000 byte, 001 half, 010 word, 011 dword.
REQ-025 biu_type_i  in  3  burst type, codebase SINGLE/INCR/WRAPn/INCRn codes.
REQ-026 biu_lock_i  in  1  hold wb_cyc_o between requests.
REQ-027 biu_we_i  in  1  write request.
REQ-028 biu_d_i  in  XLEN  write data.
REQ-029 biu_q_o  out  XLEN  read data, equal to wb_dat_i.
REQ-030 biu_ack_o  out  1  beat complete, equal to wb_ack_i & in BUS state.
REQ-031 biu_err_o  out  1  one-cycle error pulse.

Function
REQ-032 FSM states SHALL be IDLE, BUS, RETRY; biu_stb_ack_o SHALL equal biu_stb_i & IDLE.
REQ-033 On accept: SHALL latch address, we, size, type and biu_d_i; SHALL load beat count (SINGLE/INCR 1, x4 4, x8 8, x16 16); SHALL enter BUS with wb_cyc_o=wb_stb_o=1 the next cycle.
REQ-034 wb_sel_o SHALL be the size mask shifted by adr[2:0] (XLEN=64) or adr[1:0] (XLEN=32) for single beats, and all-ones for multi-beat bursts.
REQ-035 Multi-beat: wb_cti_o SHALL be 010 on all beats but the last and 111 on the last; single beats SHALL use 000; wb_bte_o SHALL follow WRAPn, otherwise 00.
REQ-036 On wb_ack_i with beats remaining, the address SHALL advance by XLEN/8 bytes, wrapping inside the aligned beats*XLEN/8 block for WRAPn.
REQ-037 On wb_ack_i of a write beat with beats remaining, biu_d_ack_o SHALL pulse and wb_dat_o SHALL load biu_d_i in the same edge.
REQ-038 On the last wb_ack_i: SHALL return to IDLE; wb_stb_o SHALL drop; wb_cyc_o SHALL drop unless biu_lock_i=1.
REQ-039 On wb_rty_i: SHALL drop wb_stb_o and wb_cyc_o for exactly one cycle (RETRY), then reissue the same beat; retry count SHALL reset on each ack.
REQ-040 wb_err_i, the MAX_RTY-th retry, or a TIMEOUT expiry SHALL pulse biu_err_o, abort remaining beats, drop wb_stb_o and wb_cyc_o, and return to IDLE.
REQ-041 Priority for simultaneous inputs SHALL be err > rty > ack; INCR/SINGLE requests SHALL never set wb_cti_o to 010.

Reset
REQ-042 HRESETn low SHALL force IDLE and zero all wb_* outputs, biu_err_o and all counters asynchronously, including mid-burst; data registers are don't-care.

Verification
REQ-043 XLEN=64, read SINGLE, size 001, adr 0x1006, ack at cycle 2 -> wb_sel_o=0xC0, cti=000, biu_ack_o one cycle, biu_adro_o=0x1006.
REQ-044 Write WRAP4, adr 0x18, acks every cycle -> beat addresses 18,00,08,10; cti 010,010,010,111; bte 01; biu_d_ack_o three pulses.
REQ-045 Read INCR8, rty on beat 3 -> one idle cycle, beat 3 reissued at the same address, 8 biu_ack_o pulses total.
REQ-046 MAX_RTY=2, rty twice on beat 1 -> biu_err_o single pulse, wb_cyc_o=0, FSM in IDLE, next request accepted.
REQ-047 TIMEOUT=5, no slave response; also err+ack same cycle -> err after 5 cycles; err wins, no biu_ack_o.
REQ-048 HRESETn low mid-INCR16 with biu_lock_i=1 -> wb_cyc_o=wb_stb_o=0 immediately; clean restart after release.
